// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: register map, CTRL fields and FSM encoding
// shared by the timer, its bus interface and the bench
package bus_timer_pkg;

  localparam int BUS_W  = 32;
  localparam int CNT_W  = 32;
  localparam int CTRL_W = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_PULSE   = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/bus_timer_if.sv
// bus_timer_if: bridge-side data-bus view of one timer.
// master drives sel/addr/we/byteen/wdata; slave returns rdata, irq.
interface bus_timer_if;
  import bus_timer_pkg::*;

  logic             sel;
  logic [BUS_W-1:0] addr;
  logic             we;
  logic [3:0]       byteen;
  logic [BUS_W-1:0] wdata;
  logic [BUS_W-1:0] rdata;
  logic             irq;

  modport master (
    output sel, addr, we, byteen, wdata,
    input  rdata, irq
  );

  modport slave (
    input  sel, addr, we, byteen, wdata,
    output rdata, irq
  );

endinterface

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped countdown timer with interrupt.
// Ports: clk, reset (sync, active-low), bus (slave: sel/addr/we/byteen/wdata in; rdata/irq out).
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [1:0] IRQ_PULSE_MODE = MODE_PULSE
) (
  input  logic       clk,
  input  logic       reset,
  bus_timer_if.slave bus
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CTRL_W-1:0] ctrl_fsm;
  logic [CNT_W-1:0]  preset_q, preset_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              irq_flag_q, irq_flag_d;

  logic [1:0]        reg_sel;
  logic              wr_ctrl;
  logic              wr_preset;
  logic [BUS_W-1:0]  ctrl_merged;
  logic [BUS_W-1:0]  rdata_c;
  logic              unused_bits;

  function automatic logic [BUS_W-1:0] merge(
    input logic [BUS_W-1:0] old_v,
    input logic [BUS_W-1:0] new_v,
    input logic [3:0]       be
  );
    logic [BUS_W-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign reg_sel   = bus.addr[3:2];
  assign wr_ctrl   = bus.sel & bus.we
                   & (reg_sel == ADDR_CTRL);
  assign wr_preset = bus.sel & bus.we
                   & (reg_sel == ADDR_PRESET);

  always_comb begin
    state_d    = state_q;
    ctrl_fsm   = ctrl_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    // any CTRL write acknowledges; a same-cycle set below wins
    if (wr_ctrl && (|bus.byteen)) irq_flag_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[CTRL_EN]) begin
          state_d = ST_IDLE;
        end else if (count_q <= CNT_W'(1)) begin
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_INT: begin
        // reserved MODE codes fall back to one-shot
        if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO]
            == IRQ_PULSE_MODE) begin
          irq_flag_d = 1'b0;
          state_d    = ST_LOAD;
        end else begin
          ctrl_fsm[CTRL_EN] = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // bus write merges over the FSM-updated CTRL, so bus bytes win
  assign ctrl_merged = merge(
    {{(BUS_W-CTRL_W){1'b0}}, ctrl_fsm},
    bus.wdata, bus.byteen);

  assign ctrl_d = wr_ctrl ? ctrl_merged[CTRL_W-1:0]
                          : ctrl_fsm;

  assign preset_d = wr_preset
    ? merge(preset_q, bus.wdata, bus.byteen)
    : preset_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rdata_c = '0;
    unique case (reg_sel)
      ADDR_CTRL:
        rdata_c = {{(BUS_W-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: rdata_c = preset_q;
      ADDR_COUNT:  rdata_c = count_q;
      ADDR_RSVD:   rdata_c = '0;
      default:     rdata_c = '0;
    endcase
  end

  assign bus.rdata = rdata_c;
  assign bus.irq   = irq_flag_q & ctrl_q[CTRL_IM];

  assign unused_bits = ^{bus.addr[BUS_W-1:4],
                         bus.addr[1:0],
                         ctrl_merged[BUS_W-1:CTRL_W]};

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed self-checking bench for bus_timer.
// Drives the bus #1 after each rising edge and samples there too.
module tb_bus_timer;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;

  bus_timer_if bus();

  bus_timer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [3:0]  be
  );
    bus.sel    = 1'b1;
    bus.we     = 1'b1;
    bus.addr   = a;
    bus.wdata  = d;
    bus.byteen = be;
    tick();
    bus.sel    = 1'b0;
    bus.we     = 1'b0;
    bus.byteen = 4'h0;
  endtask

  task automatic rd(
    input  logic [31:0] a,
    output logic [31:0] d
  );
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] a;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i * 4);
      rd(a, v);
      checks++;
      if (v !== 32'h0)
        $display("FAIL reset_rd addr=%h got=%h exp=0",
                 a, v);
      else passed++;
    end
    checks++;
    if (bus.irq !== 1'b0)
      $display("FAIL reset_irq got=%b exp=0", bus.irq);
    else passed++;
  endtask

  task automatic test_oneshot();
    logic [31:0] v;
    do_reset();
    bus_wr(32'h4, 32'd5, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    tick();
    for (int k = 2; k <= 6; k++) begin
      tick();
      rd(32'h8, v);
      checks++;
      if (v !== 32'(7 - k))
        $display("FAIL os_count edge=%0d got=%0d exp=%0d",
                 k, v, 7 - k);
      else passed++;
      checks++;
      if (bus.irq !== 1'b0)
        $display("FAIL os_irq_early edge=%0d got=%b exp=0",
                 k, bus.irq);
      else passed++;
    end
    tick();
    checks++;
    if (bus.irq !== 1'b1)
      $display("FAIL os_irq_set got=%b exp=1", bus.irq);
    else passed++;
    tick();
    rd(32'h0, v);
    checks++;
    if (v !== 32'h8)
      $display("FAIL os_en_clr got=%h exp=8", v);
    else passed++;
    checks++;
    if (bus.irq !== 1'b1)
      $display("FAIL os_irq_held got=%b exp=1", bus.irq);
    else passed++;
    bus_wr(32'h0, 32'h0, 4'hF);
    checks++;
    if (bus.irq !== 1'b0)
      $display("FAIL os_irq_ack got=%b exp=0", bus.irq);
    else passed++;
  endtask

  task automatic test_small_preset();
    logic [31:0] v;
    for (int p = 0; p <= 1; p++) begin
      do_reset();
      bus_wr(32'h4, 32'(p), 4'hF);
      bus_wr(32'h0, 32'h9, 4'hF);
      tick();
      tick();
      checks++;
      if (bus.irq !== 1'b0)
        $display("FAIL small_e2 p=%0d got=%b exp=0",
                 p, bus.irq);
      else passed++;
      tick();
      checks++;
      if (bus.irq !== 1'b1)
        $display("FAIL small_e3 p=%0d got=%b exp=1",
                 p, bus.irq);
      else passed++;
      rd(32'h8, v);
      checks++;
      if (v !== 32'h0)
        $display("FAIL small_cnt p=%0d got=%h exp=0",
                 p, v);
      else passed++;
    end
  endtask

  task automatic test_reload();
    int   pulses;
    logic exp;
    pulses = 0;
    do_reset();
    bus_wr(32'h4, 32'd3, 4'hF);
    bus_wr(32'h0, 32'hB, 4'hF);
    for (int e = 1; e <= 21; e++) begin
      tick();
      exp = (e >= 5) && (e <= 20) && ((e % 5) == 0);
      checks++;
      if (bus.irq !== exp)
        $display("FAIL reload_irq edge=%0d got=%b exp=%b",
                 e, bus.irq, exp);
      else passed++;
      if (bus.irq === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 4)
      $display("FAIL reload_pulses got=%0d exp=4", pulses);
    else passed++;
  endtask

  task automatic test_byteen();
    logic [31:0] v;
    do_reset();
    bus_wr(32'h4, 32'hAABBCCDD, 4'b0101);
    rd(32'h4, v);
    checks++;
    if (v !== 32'h00BB00DD)
      $display("FAIL be_preset got=%h exp=00bb00dd", v);
    else passed++;
    bus.sel    = 1'b0;
    bus.we     = 1'b1;
    bus.addr   = 32'h4;
    bus.wdata  = 32'hFFFFFFFF;
    bus.byteen = 4'hF;
    tick();
    bus.we     = 1'b0;
    bus.byteen = 4'h0;
    rd(32'h4, v);
    checks++;
    if (v !== 32'h00BB00DD)
      $display("FAIL be_nosel got=%h exp=00bb00dd", v);
    else passed++;
    bus_wr(32'h8, 32'h1234, 4'hF);
    rd(32'h8, v);
    checks++;
    if (v !== 32'h0)
      $display("FAIL be_count_ro got=%h exp=0", v);
    else passed++;
    bus_wr(32'hC, 32'h55, 4'hF);
    rd(32'hC, v);
    checks++;
    if (v !== 32'h0)
      $display("FAIL be_rsvd got=%h exp=0", v);
    else passed++;
    bus_wr(32'h0, 32'hFFFFFFFF, 4'hF);
    rd(32'h0, v);
    checks++;
    if (v !== 32'hF)
      $display("FAIL be_ctrl got=%h exp=f", v);
    else passed++;
  endtask

  task automatic test_mask();
    logic [31:0] v;
    do_reset();
    bus_wr(32'h4, 32'd2, 4'hF);
    bus_wr(32'h0, 32'h1, 4'hF);
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (bus.irq !== 1'b0)
        $display("FAIL mask_irq edge=%0d got=%b exp=0",
                 e, bus.irq);
      else passed++;
    end
    rd(32'h0, v);
    checks++;
    if (v !== 32'h0)
      $display("FAIL mask_en got=%h exp=0", v);
    else passed++;
    do_reset();
    bus_wr(32'h4, 32'd2, 4'hF);
    bus_wr(32'h0, 32'h1, 4'hF);
    tick();
    tick();
    tick();
    bus_wr(32'h0, 32'h9, 4'hF);
    checks++;
    if (bus.irq !== 1'b1)
      $display("FAIL mask_set_wins got=%b exp=1", bus.irq);
    else passed++;
    tick();
    rd(32'h0, v);
    checks++;
    if (v !== 32'h8)
      $display("FAIL mask_en_clr got=%h exp=8", v);
    else passed++;
    checks++;
    if (bus.irq !== 1'b1)
      $display("FAIL mask_irq_hold got=%b exp=1", bus.irq);
    else passed++;
  endtask

  task automatic test_mid_run();
    logic [31:0] v;
    do_reset();
    bus_wr(32'h4, 32'd6, 4'hF);
    bus_wr(32'h0, 32'h1, 4'hF);
    tick();
    tick();
    tick();
    bus_wr(32'h0, 32'h0, 4'hF);
    for (int e = 4; e <= 7; e++) begin
      rd(32'h8, v);
      checks++;
      if (v !== 32'd4)
        $display("FAIL freeze edge=%0d got=%0d exp=4",
                 e, v);
      else passed++;
      tick();
    end
    do_reset();
    bus_wr(32'h4, 32'd6, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    tick();
    tick();
    bus_wr(32'h4, 32'd9, 4'hF);
    rd(32'h4, v);
    checks++;
    if (v !== 32'd9)
      $display("FAIL pre_mid_rd got=%0d exp=9", v);
    else passed++;
    for (int k = 3; k <= 7; k++) begin
      rd(32'h8, v);
      checks++;
      if (v !== 32'(8 - k))
        $display("FAIL pre_mid edge=%0d got=%0d exp=%0d",
                 k, v, 8 - k);
      else passed++;
      tick();
    end
    checks++;
    if (bus.irq !== 1'b1)
      $display("FAIL pre_mid_irq got=%b exp=1", bus.irq);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int          hits;
    do_reset();
    bus_wr(32'h4, 32'd5, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    for (int e = 1; e <= 4; e++) tick();
    rd(32'h8, v);
    checks++;
    if (v !== 32'd3)
      $display("FAIL rmid_pre got=%0d exp=3", v);
    else passed++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd(32'(i * 4), v);
      checks++;
      if (v !== 32'h0)
        $display("FAIL rmid_reg idx=%0d got=%h exp=0",
                 i, v);
      else passed++;
    end
    hits = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (bus.irq !== 1'b0) hits++;
    end
    checks++;
    if (hits != 0)
      $display("FAIL rmid_quiet got=%0d exp=0", hits);
    else passed++;
    do_reset();
    bus_wr(32'h4, 32'd1, 4'hF);
    bus_wr(32'h0, 32'h9, 4'hF);
    tick();
    tick();
    tick();
    checks++;
    if (bus.irq !== 1'b1)
      $display("FAIL rirq_pre got=%b exp=1", bus.irq);
    else passed++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (bus.irq !== 1'b0)
      $display("FAIL rirq_post got=%b exp=0", bus.irq);
    else passed++;
    rd(32'h0, v);
    checks++;
    if (v !== 32'h0)
      $display("FAIL rirq_ctrl got=%h exp=0", v);
    else passed++;
  endtask

  initial begin
    bus.sel    = 1'b0;
    bus.we     = 1'b0;
    bus.addr   = 32'h0;
    bus.wdata  = 32'h0;
    bus.byteen = 4'h0;
    test_reset();
    test_oneshot();
    test_small_preset();
    test_reload();
    test_byteen();
    test_mask();
    test_mid_run();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
